// File: rtl/kim1_panel_emulator.sv
// Panel-side emulation of the KIM-1 keypad matrix and 6-digit LED scan capture.
// Optional hex readout of the captured display is enabled by PANEL_HEX_DECODE_EN.
module kim1_panel_emulator #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int HOLD_CYCLES    = 50000,
  parameter int RELEASE_CYCLES = 50000,
  parameter int BLANK_TIMEOUT  = 200000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  KB_ROW,
  output logic [6:0]  KB_COL,
  input  logic [5:0]  LED_DIG,
  input  logic [6:0]  LED_SEG,
  input  logic        key_valid,
  input  logic [4:0]  key_code,
  output logic        key_ready,
  output logic        key_err,
  output logic [41:0] disp,
  output logic        disp_strobe
`ifdef PANEL_HEX_DECODE_EN
  ,
  output logic [15:0] hex_addr,
  output logic [7:0]  hex_data,
  output logic        hex_ok
`endif
);

  localparam int PhaseMax = (HOLD_CYCLES > RELEASE_CYCLES) ? HOLD_CYCLES : RELEASE_CYCLES;
  localparam int PW = $clog2(PhaseMax + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int BW = $clog2(BLANK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, HOLD, RELEASE} keyState_e;

  keyState_e       state_q;
  logic [PW-1:0]   phaseCnt_q;
  logic [1:0]      row_q;
  logic [2:0]      col_q;
  logic            keyReady_q;
  logic            keyErr_q;
  logic [6:0]      kbCol_q;

  logic [1:0]      codeRow;
  logic [2:0]      codeCol;

  always_comb begin
    codeRow = 2'd0;
    codeCol = key_code[2:0];
    if (key_code >= 5'd14) begin
      codeRow = 2'd2;
      codeCol = 3'(key_code - 5'd14);
    end else if (key_code >= 5'd7) begin
      codeRow = 2'd1;
      codeCol = 3'(key_code - 5'd7);
    end
  end

  // Column response is a registered function of the row the firmware is scanning right now.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      phaseCnt_q <= '0;
      row_q      <= '0;
      col_q      <= '0;
      keyReady_q <= 1'b1;
      keyErr_q   <= 1'b0;
      kbCol_q    <= 7'h7F;
    end else begin
      keyErr_q <= 1'b0;
      kbCol_q  <= (state_q == HOLD && !KB_ROW[row_q]) ? ~(7'd1 << col_q) : 7'h7F;
      case (state_q)
        IDLE: begin
          if (key_valid && keyReady_q) begin
            if (key_code > 5'd20) begin
              keyErr_q <= 1'b1;
            end else begin
              row_q      <= codeRow;
              col_q      <= codeCol;
              state_q    <= HOLD;
              phaseCnt_q <= '0;
              keyReady_q <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (phaseCnt_q == PW'(HOLD_CYCLES - 1)) begin
            state_q    <= RELEASE;
            phaseCnt_q <= '0;
          end else begin
            phaseCnt_q <= phaseCnt_q + 1'b1;
          end
        end
        RELEASE: begin
          if (phaseCnt_q == PW'(RELEASE_CYCLES - 1)) begin
            state_q    <= IDLE;
            phaseCnt_q <= '0;
            keyReady_q <= 1'b1;
          end else begin
            phaseCnt_q <= phaseCnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign KB_COL    = kbCol_q;
  assign key_ready = keyReady_q;
  assign key_err   = keyErr_q;

  logic [5:0]    prevDig_q;
  logic [6:0]    prevSeg_q;
  logic [SW-1:0] stab_q, stab_d;
  logic [41:0]   disp_q, disp_d;
  logic [BW-1:0] blank_q [6];
  logic [BW-1:0] blank_d [6];
  logic          strobe_q;
  logic          capValid, sameAsPrev, capture;
  logic [2:0]    capDigit;

  // A digit is latched once, on the cycle its bus has been unchanged for SETTLE_CYCLES compares.
  always_comb begin
    capValid   = ($countones(~LED_DIG) == 1);
    sameAsPrev = (LED_DIG == prevDig_q) && (LED_SEG == prevSeg_q);
    stab_d     = stab_q;
    if (!capValid || !sameAsPrev) begin
      stab_d = '0;
    end else if (stab_q != SW'(SETTLE_CYCLES)) begin
      stab_d = stab_q + 1'b1;
    end
    capture  = capValid && sameAsPrev && (stab_q == SW'(SETTLE_CYCLES - 1));
    capDigit = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (!LED_DIG[i]) capDigit = 3'(i);
    end
    disp_d = disp_q;
    for (int d = 0; d < 6; d++) begin
      blank_d[d] = blank_q[d];
      if (capture && capDigit == 3'(d)) begin
        disp_d[7*d +: 7] = ~LED_SEG;
        blank_d[d]       = '0;
      end else begin
        if (blank_q[d] != BW'(BLANK_TIMEOUT)) blank_d[d] = blank_q[d] + 1'b1;
        if (blank_q[d] == BW'(BLANK_TIMEOUT - 1)) disp_d[7*d +: 7] = 7'h00;
      end
    end
  end

  // The strobe rises together with the first cycle that shows the new framebuffer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prevDig_q <= 6'h3F;
      prevSeg_q <= 7'h7F;
      stab_q    <= '0;
      disp_q    <= '0;
      strobe_q  <= 1'b0;
      for (int d = 0; d < 6; d++) blank_q[d] <= '0;
    end else begin
      prevDig_q <= LED_DIG;
      prevSeg_q <= LED_SEG;
      stab_q    <= stab_d;
      disp_q    <= disp_d;
      strobe_q  <= (disp_d != disp_q);
      for (int d = 0; d < 6; d++) blank_q[d] <= blank_d[d];
    end
  end

  assign disp        = disp_q;
  assign disp_strobe = strobe_q;

`ifdef PANEL_HEX_DECODE_EN
  function automatic logic [4:0] fontDecode(input logic [6:0] seg);
    case (seg)
      7'h3F: return 5'h10;
      7'h06: return 5'h11;
      7'h5B: return 5'h12;
      7'h4F: return 5'h13;
      7'h66: return 5'h14;
      7'h6D: return 5'h15;
      7'h7D: return 5'h16;
      7'h07: return 5'h17;
      7'h7F: return 5'h18;
      7'h6F: return 5'h19;
      7'h77: return 5'h1A;
      7'h7C: return 5'h1B;
      7'h39: return 5'h1C;
      7'h5E: return 5'h1D;
      7'h79: return 5'h1E;
      7'h71: return 5'h1F;
      default: return 5'h00;
    endcase
  endfunction

  logic [4:0] dec [6];

  always_comb begin
    for (int d = 0; d < 6; d++) dec[d] = fontDecode(disp_q[7*d +: 7]);
  end

  // Digit 0 is the leftmost, so it carries the most significant address nibble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hex_addr <= '0;
      hex_data <= '0;
      hex_ok   <= 1'b0;
    end else begin
      hex_addr <= {dec[0][3:0], dec[1][3:0], dec[2][3:0], dec[3][3:0]};
      hex_data <= {dec[4][3:0], dec[5][3:0]};
      hex_ok   <= dec[0][4] & dec[1][4] & dec[2][4] & dec[3][4] & dec[4][4] & dec[5][4];
    end
  end
`endif

endmodule
